// File: rtl/evm_vote_controller.sv
// EVM ballot controller: one-hot vote capture, per-candidate saturating tallies,
// post-vote lockout with button-release interlock, and sealed result readout.
module evm_vote_controller #(
   parameter int unsigned NUM_CANDIDATES = 4,
   parameter int unsigned COUNT_W        = 8,
   parameter int unsigned LOCKOUT_CYCLES = 4,
   parameter int unsigned SEL_W          = $clog2(NUM_CANDIDATES)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       control,
   input  logic                       mode,
   input  logic [NUM_CANDIDATES-1:0]  push,
   input  logic                       voter_eligible,
   input  logic                       officer_id_status,
   input  logic [SEL_W-1:0]           result_sel,
   output logic                       status_led,
   output logic                       vote_valid,
   output logic [SEL_W-1:0]           vote_party,
   output logic                       multi_press_err,
   output logic                       sealed,
   output logic [COUNT_W-1:0]         result_count,
   output logic [COUNT_W+SEL_W-1:0]   total_votes
);

   localparam int unsigned TOTAL_W = COUNT_W + SEL_W;
   localparam int unsigned LOCK_W  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
   localparam int unsigned PC_W    = $clog2(NUM_CANDIDATES + 1);

   localparam logic [COUNT_W-1:0] TALLY_MAX = '1;
   localparam logic [TOTAL_W-1:0] TOTAL_MAX = '1;
   localparam logic [LOCK_W-1:0]  LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_CHECK   = 3'd0,
      S_IDLE    = 3'd1,
      S_CAST    = 3'd2,
      S_LOCKOUT = 3'd3,
      S_RELEASE = 3'd4,
      S_SEAL    = 3'd5
   } state_t;

   state_t              state_q;
   state_t              state_n;
   logic [LOCK_W-1:0]   lock_cnt_q;
   logic [LOCK_W-1:0]   lock_cnt_n;
   logic [COUNT_W-1:0]  tally_q [NUM_CANDIDATES];

   logic [PC_W-1:0]     press_cnt;
   logic [SEL_W-1:0]    press_idx;
   logic                accept;
   logic                multi_n;
   logic                led_n;
   logic                vv_n;
   logic [SEL_W-1:0]    party_n;
   logic                sealed_n;
   logic [COUNT_W-1:0]  rc_n;

   // Count pressed buttons and locate the pressed one (meaningful when exactly one)
   always_comb begin
      press_cnt = '0;
      press_idx = '0;
      for (int i = 0; i < int'(NUM_CANDIDATES); i++) begin
         if (push[i]) begin
            press_cnt = press_cnt + PC_W'(1);
            press_idx = SEL_W'(i);
         end
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n    = state_q;
      lock_cnt_n = lock_cnt_q;
      accept     = 1'b0;
      multi_n    = 1'b0;

      case (state_q)
         S_CHECK: begin
            if (mode && control && officer_id_status) begin
               state_n = S_IDLE;
            end
         end
         S_IDLE: begin
            if (!mode) begin
               state_n = S_SEAL;
            end else if (voter_eligible && officer_id_status) begin
               if (press_cnt == PC_W'(1)) begin
                  accept  = 1'b1;
                  state_n = S_CAST;
               end else if (press_cnt > PC_W'(1)) begin
                  multi_n = 1'b1;
               end
            end
         end
         S_CAST: begin
            lock_cnt_n = '0;
            state_n    = S_LOCKOUT;
         end
         S_LOCKOUT: begin
            if (lock_cnt_q == LOCK_LAST) begin
               state_n = S_RELEASE;
            end else begin
               lock_cnt_n = lock_cnt_q + LOCK_W'(1);
            end
         end
         S_RELEASE: begin
            // A still-held button must be let go before the next voter is served
            if (push == '0) begin
               state_n = S_IDLE;
            end
         end
         S_SEAL: begin
            state_n = S_SEAL;
         end
         default: begin
            state_n = S_CHECK;
         end
      endcase

      led_n    = (state_n == S_IDLE);
      vv_n     = accept;
      party_n  = accept ? press_idx : '0;
      sealed_n = (state_n == S_SEAL);

      rc_n = '0;
      if (state_n == S_SEAL) begin
         for (int i = 0; i < int'(NUM_CANDIDATES); i++) begin
            if (result_sel == SEL_W'(i)) begin
               rc_n = tally_q[i];
            end
         end
      end
   end

   // State register, lockout counter and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q         <= S_CHECK;
         lock_cnt_q      <= '0;
         status_led      <= 1'b0;
         vote_valid      <= 1'b0;
         vote_party      <= '0;
         multi_press_err <= 1'b0;
         sealed          <= 1'b0;
         result_count    <= '0;
      end else begin
         state_q         <= state_n;
         lock_cnt_q      <= lock_cnt_n;
         status_led      <= led_n;
         vote_valid      <= vv_n;
         vote_party      <= party_n;
         multi_press_err <= multi_n;
         sealed          <= sealed_n;
         result_count    <= rc_n;
      end
   end

   // Saturating per-candidate tallies, bumped on the edge a vote is accepted
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < int'(NUM_CANDIDATES); i++) begin
            tally_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(NUM_CANDIDATES); i++) begin
            if (accept && (press_idx == SEL_W'(i)) && (tally_q[i] != TALLY_MAX)) begin
               tally_q[i] <= tally_q[i] + COUNT_W'(1);
            end
         end
      end
   end

   // Saturating grand total of accepted votes
   always_ff @(posedge clk) begin
      if (!reset) begin
         total_votes <= '0;
      end else if (accept && (total_votes != TOTAL_MAX)) begin
         total_votes <= total_votes + TOTAL_W'(1);
      end
   end

endmodule

// File: tb/tb_evm_vote_controller.sv
// Bench for evm_vote_controller: directed vector table, hand-written corner
// sequences and constrained-random stimulus against a behavioural model.
module tb_evm_vote_controller;

   localparam int unsigned N    = 4;
   localparam int unsigned CW   = 2;
   localparam int unsigned LOCK = 4;
   localparam int unsigned SW   = $clog2(N);
   localparam int unsigned TW   = CW + SW;
   localparam int TALLY_MAX = (1 << CW) - 1;
   localparam int TOTAL_MAX = (1 << TW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          control;
   logic          mode;
   logic [N-1:0]  push;
   logic          voter_eligible;
   logic          officer_id_status;
   logic [SW-1:0] result_sel;
   logic          status_led;
   logic          vote_valid;
   logic [SW-1:0] vote_party;
   logic          multi_press_err;
   logic          sealed;
   logic [CW-1:0] result_count;
   logic [TW-1:0] total_votes;

   always #5 clk = ~clk;

   evm_vote_controller #(
      .NUM_CANDIDATES (N),
      .COUNT_W        (CW),
      .LOCKOUT_CYCLES (LOCK)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .control           (control),
      .mode              (mode),
      .push              (push),
      .voter_eligible    (voter_eligible),
      .officer_id_status (officer_id_status),
      .result_sel        (result_sel),
      .status_led        (status_led),
      .vote_valid        (vote_valid),
      .vote_party        (vote_party),
      .multi_press_err   (multi_press_err),
      .sealed            (sealed),
      .result_count      (result_count),
      .total_votes       (total_votes)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_all(input string tag, input logic led, input logic vv,
                          input logic [SW-1:0] pty, input logic err, input logic sld,
                          input logic [CW-1:0] rc, input logic [TW-1:0] tot);
      chk({tag, " status_led"}, int'(status_led), int'(led));
      chk({tag, " vote_valid"}, int'(vote_valid), int'(vv));
      if (vv) chk({tag, " vote_party"}, int'(vote_party), int'(pty));
      chk({tag, " multi_press_err"}, int'(multi_press_err), int'(err));
      chk({tag, " sealed"}, int'(sealed), int'(sld));
      chk({tag, " result_count"}, int'(result_count), int'(rc));
      chk({tag, " total_votes"}, int'(total_votes), int'(tot));
   endtask

   // ---------------- behavioural model ----------------
   bit m_on, m_sealed, m_rel;
   int m_pend;
   int m_tally [N];
   int m_total;
   logic          e_led, e_vv, e_err, e_sld;
   logic [SW-1:0] e_pty;
   logic [CW-1:0] e_rc;
   logic [TW-1:0] e_tot;

   task automatic model_step();
      int pc;
      int idx;
      e_vv  = 1'b0;
      e_err = 1'b0;
      e_pty = '0;
      if (!reset) begin
         m_on = 0; m_sealed = 0; m_rel = 0; m_pend = 0; m_total = 0;
         for (int i = 0; i < N; i++) m_tally[i] = 0;
      end else if (m_sealed) begin
         // frozen
      end else if (!m_on) begin
         if (mode && control && officer_id_status) m_on = 1;
      end else if (m_pend > 0) begin
         m_pend = m_pend - 1;
         if (m_pend == 0) m_rel = 1;
      end else if (m_rel) begin
         if (push == '0) m_rel = 0;
      end else if (!mode) begin
         m_sealed = 1;
      end else if (voter_eligible && officer_id_status) begin
         pc = $countones(push);
         if (pc == 1) begin
            idx = 0;
            for (int i = 0; i < N; i++) if (push[i]) idx = i;
            if (m_tally[idx] < TALLY_MAX) m_tally[idx] = m_tally[idx] + 1;
            if (m_total < TOTAL_MAX) m_total = m_total + 1;
            m_pend = LOCK + 1;
            e_vv   = 1'b1;
            e_pty  = SW'(idx);
         end else if (pc > 1) begin
            e_err = 1'b1;
         end
      end
      e_led = m_on && !m_sealed && (m_pend == 0) && !m_rel;
      e_sld = m_sealed;
      e_rc  = (m_sealed && int'(result_sel) < N) ? CW'(m_tally[int'(result_sel)]) : '0;
      e_tot = TW'(m_total);
   endtask

   task automatic tick_m(input string tag);
      @(posedge clk);
      model_step();
      #1;
      cmp_all(tag, e_led, e_vv, e_pty, e_err, e_sld, e_rc, e_tot);
   endtask

   task automatic set_in(input logic rst, input logic md, input logic ctl, input logic off,
                         input logic elig, input logic [N-1:0] p, input logic [SW-1:0] sel);
      reset = rst; mode = md; control = ctl; officer_id_status = off;
      voter_eligible = elig; push = p; result_sel = sel;
   endtask

   task automatic start_session();
      set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
      tick_m("rst");
      tick_m("rst");
      reset = 1'b1;
      tick_m("enable");
   endtask

   task automatic vote(input int idx);
      push = N'(1) << idx; voter_eligible = 1'b1; officer_id_status = 1'b1; mode = 1'b1;
      tick_m($sformatf("vote%0d", idx));
      push = '0;
      repeat (LOCK + 2) tick_m($sformatf("vote%0d_lock", idx));
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic          rst, md, ctl, off, elig;
      logic [N-1:0]  p;
      logic [SW-1:0] sel;
      logic          led, vv;
      logic [SW-1:0] pty;
      logic          err, sld;
      logic [CW-1:0] rc;
      logic [TW-1:0] tot;
   } vec_t;

   function automatic vec_t mk(input logic rst, md, ctl, off, elig, input logic [N-1:0] p,
                               input logic [SW-1:0] sel, input logic led, vv,
                               input logic [SW-1:0] pty, input logic err, sld,
                               input logic [CW-1:0] rc, input logic [TW-1:0] tot);
      vec_t v;
      v.rst = rst; v.md = md; v.ctl = ctl; v.off = off; v.elig = elig; v.p = p; v.sel = sel;
      v.led = led; v.vv = vv; v.pty = pty; v.err = err; v.sld = sld; v.rc = rc; v.tot = tot;
      return v;
   endfunction

   vec_t vecs [21];

   initial begin
      int r;
      //             rst md ctl off elg push     sel | led vv pty err sld rc tot
      vecs[0]  = mk(0, 0, 0, 0, 0, 4'b0000, 0,   0, 0, 0, 0, 0, 0, 0);
      vecs[1]  = mk(0, 1, 1, 1, 0, 4'b0000, 0,   0, 0, 0, 0, 0, 0, 0);
      vecs[2]  = mk(1, 1, 1, 1, 0, 4'b0000, 0,   1, 0, 0, 0, 0, 0, 0);
      vecs[3]  = mk(1, 1, 0, 1, 1, 4'b0100, 0,   0, 1, 2, 0, 0, 0, 1);
      for (int i = 4; i <= 10; i++)
         vecs[i] = mk(1, 1, 0, 1, 1, 4'b0100, 0, 0, 0, 0, 0, 0, 0, 1);
      vecs[11] = mk(1, 1, 0, 1, 1, 4'b0000, 0,   1, 0, 0, 0, 0, 0, 1);
      vecs[12] = mk(1, 1, 0, 1, 1, 4'b0011, 0,   1, 0, 0, 1, 0, 0, 1);
      vecs[13] = mk(1, 1, 0, 1, 1, 4'b1100, 0,   1, 0, 0, 1, 0, 0, 1);
      vecs[14] = mk(1, 1, 0, 1, 1, 4'b0000, 0,   1, 0, 0, 0, 0, 0, 1);
      vecs[15] = mk(1, 1, 0, 1, 0, 4'b0001, 0,   1, 0, 0, 0, 0, 0, 1);
      vecs[16] = mk(1, 1, 0, 0, 1, 4'b0001, 0,   1, 0, 0, 0, 0, 0, 1);
      vecs[17] = mk(1, 0, 0, 1, 1, 4'b0000, 2,   0, 0, 0, 0, 1, 1, 1);
      vecs[18] = mk(1, 0, 0, 1, 1, 4'b0000, 0,   0, 0, 0, 0, 1, 0, 1);
      vecs[19] = mk(1, 1, 1, 1, 1, 4'b0100, 2,   0, 0, 0, 0, 1, 1, 1);
      vecs[20] = mk(0, 1, 1, 1, 1, 4'b0000, 2,   0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 21; i++) begin
         set_in(vecs[i].rst, vecs[i].md, vecs[i].ctl, vecs[i].off, vecs[i].elig,
                vecs[i].p, vecs[i].sel);
         @(posedge clk);
         #1;
         cmp_all($sformatf("vec%0d", i), vecs[i].led, vecs[i].vv, vecs[i].pty,
                 vecs[i].err, vecs[i].sld, vecs[i].rc, vecs[i].tot);
      end

      // Saturation: five votes for candidate 0 with a 2-bit tally
      start_session();
      repeat (5) vote(0);
      mode = 1'b0; result_sel = 2'd0;
      tick_m("sat_seal");
      chk("sat tally0", int'(result_count), 3);
      chk("sat total", int'(total_votes), 5);

      // Mixed votes, seal, readout, frozen tallies, reset clears
      start_session();
      vote(0); vote(1); vote(1); vote(3);
      mode = 1'b0; result_sel = 2'd1;
      tick_m("seal_sel1");
      chk("seal rc sel1", int'(result_count), 2);
      chk("seal flag", int'(sealed), 1);
      result_sel = 2'd2;
      tick_m("seal_sel2");
      chk("seal rc sel2", int'(result_count), 0);
      result_sel = 2'd3;
      tick_m("seal_sel3");
      chk("seal rc sel3", int'(result_count), 1);
      mode = 1'b1; control = 1'b1; push = 4'b0001; voter_eligible = 1'b1;
      repeat (3) tick_m("seal_push");
      chk("seal frozen total", int'(total_votes), 4);
      chk("seal no vote", int'(vote_valid), 0);
      reset = 1'b0; push = '0;
      tick_m("seal_reset");
      chk("post reset sealed", int'(sealed), 0);
      chk("post reset total", int'(total_votes), 0);
      reset = 1'b1;
      tick_m("reenable");
      mode = 1'b0; result_sel = 2'd1;
      tick_m("reseal");
      chk("cleared tally1", int'(result_count), 0);

      // Ineligible voter, then reset in the middle of the lockout
      start_session();
      push = 4'b0001; voter_eligible = 1'b0;
      repeat (3) tick_m("inelig");
      chk("inelig total", int'(total_votes), 0);
      push = 4'b0100; voter_eligible = 1'b1;
      tick_m("mid_cast");
      chk("mid cast valid", int'(vote_valid), 1);
      push = '0; voter_eligible = 1'b0;
      repeat (2) tick_m("mid_lock");
      reset = 1'b0;
      tick_m("mid_reset");
      chk("mid reset led", int'(status_led), 0);
      chk("mid reset total", int'(total_votes), 0);
      reset = 1'b1; mode = 1'b1; control = 1'b1; officer_id_status = 1'b1;
      tick_m("mid_reenable");
      mode = 1'b0; result_sel = 2'd2;
      tick_m("mid_seal");
      chk("mid cleared tally2", int'(result_count), 0);

      // Constrained-random run against the model
      start_session();
      for (int c = 0; c < 4000; c++) begin
         reset             = ($urandom_range(0, 63) != 0);
         mode              = ($urandom_range(0, 39) != 0);
         control           = 1'($urandom_range(0, 1));
         officer_id_status = ($urandom_range(0, 7) != 0);
         voter_eligible    = ($urandom_range(0, 5) != 0);
         result_sel        = SW'($urandom_range(0, N - 1));
         r = $urandom_range(0, 9);
         if (r < 4)      push = '0;
         else if (r < 8) push = N'(1) << $urandom_range(0, N - 1);
         else            push = N'($urandom);
         tick_m("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/evm_vote_controller.md
Name: evm_vote_controller

Overview:
- Parametrised next-generation ballot controller for the EVM: NUM_CANDIDATES one-hot push buttons, on-chip saturating per-candidate tallies, post-vote lockout with button-release interlock, seal mode with result readout.
- Sits between the ballot-unit button/eligibility inputs and the control-unit display/result logic.
- Replaces the fixed 4-button FSM plus external vote counters.

Parameters:
- NUM_CANDIDATES, 4, number of candidate push buttons/tallies (2..16)
- COUNT_W, 8, width of each per-candidate tally
- LOCKOUT_CYCLES, 4, cycles status_led stays low after a vote (>=1)
- SEL_W, $clog2(NUM_CANDIDATES), width of candidate index fields

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset; sampled on rising clk edge
- control  in  1  officer control key
- mode  in  1  1 = voting mode, 0 = seal request
- push  in  NUM_CANDIDATES  candidate buttons, bit i = candidate i
- voter_eligible  in  1  current voter verified
- officer_id_status  in  1  presiding officer authenticated
- result_sel  in  SEL_W  candidate index for readout
- status_led  out  1  1 = ready to accept a vote
- vote_valid  out  1  one-cycle pulse per accepted vote
- vote_party  out  SEL_W  index of accepted candidate, valid with vote_valid
- multi_press_err  out  1  more than one button pressed while ready
- sealed  out  1  machine sealed, tallies frozen
- result_count  out  COUNT_W  tally[result_sel], nonzero only when sealed
- total_votes  out  COUNT_W+SEL_W  sum of accepted votes, saturating

Behaviour:
- All outputs registered. Reset (reset==0 at rising edge) → state CHECK; all tallies, total_votes, lockout counter = 0; all outputs 0.
- Reset has priority over every state, including SEAL and mid-lockout. Tallies clear on reset.
- States: CHECK, IDLE, CAST, LOCKOUT, RELEASE, SEAL.
- CHECK: status_led=0. Goes to IDLE when mode==1 && control==1 && officer_id_status==1; otherwise stays in CHECK.
- IDLE: status_led=1. Evaluate in priority order:
  - mode==0 → SEAL.
  - Else if !(voter_eligible && officer_id_status) → stay IDLE; push ignored.
  - Else if exactly one push bit is set → latch its index, go to CAST.
  - Else if two or more push bits are set → multi_press_err=1 next cycle (level, every cycle the condition holds); no count; stay IDLE.
  - Else (no button) → stay IDLE.
- CAST (1 cycle):
  - tally[idx] increments, saturating at 2^COUNT_W-1.
  - total_votes increments, saturating at its own maximum.
  - vote_valid=1 and vote_party=idx for exactly this cycle.
  - status_led=0. → LOCKOUT.
- LOCKOUT: status_led=0; counter runs LOCKOUT_CYCLES cycles, then → RELEASE.
- RELEASE: status_led=0; stays until push==0 for one sampled cycle, then → IDLE. A held button never casts a second vote.
- Total cycles from IDLE sample to earliest re-ready (status_led=1): 1 (CAST) + LOCKOUT_CYCLES + 1 (RELEASE).
- SEAL: terminal until reset.
  - sealed=1, status_led=0; push, mode, control ignored; tallies frozen.
  - result_count=tally[result_sel], updated 1 cycle after result_sel changes.
  - result_sel ≥ NUM_CANDIDATES → result_count=0.
- Outside SEAL, result_count=0.
- Eligibility dropping during CAST, LOCKOUT or RELEASE does not cancel a vote already latched in IDLE.
- mode==0 during CAST, LOCKOUT or RELEASE is honoured only after return to IDLE, so the in-flight vote is counted.
- vote_valid is never asserted outside CAST. multi_press_err is 0 outside IDLE.

Test Plan:
- Reset low 2 cycles, release; mode=1, control=1, officer=1 → IDLE 1 cycle later, status_led=1; all tallies 0.
- eligible=1, push=4'b0100 held for 20 cycles → exactly one vote_valid pulse with vote_party=2; tally[2]=1; status_led low for 1+4+≥1 cycles; returns high only after push released.
- push=4'b0011 with eligible=1 → multi_press_err=1, no vote_valid, all tallies unchanged; release → err=0.
- COUNT_W=2: 5 votes for candidate 0 → tally[0] saturates at 3, total_votes=5.
- Votes 0,1,1,3, then mode=0 → SEAL, sealed=1; result_sel=1 → result_count=2; result_sel=2 → 0; later push has no effect; reset low → all tallies 0, state CHECK.
- push=4'b0001 with voter_eligible=0 → no vote; reset asserted mid-LOCKOUT → next cycle state CHECK, status_led=0, tallies 0.
